pio_out_pulse: RTL and testbench



---
 rtl/pio_pkg.sv | 20 ++
 rtl/pio_pulse_timer.sv | 54 +++++
 rtl/pio_out_pulse.sv | 111 +++++++++++
 tb/tb_pio_out_pulse.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the pulse-capable output PIO: register map, STATUS bits, pulse FSM states.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLR       = 3'd2;
  localparam logic [2:0] ADDR_PULSE     = 3'd3;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
  localparam logic [2:0] ADDR_STATUS    = 3'd5;

  localparam int unsigned STATUS_BUSY = 0;
  localparam int unsigned STATUS_DONE = 1;
  localparam int unsigned STATUS_IE   = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/pio_pulse_timer.sv
// Loadable down-counter that holds ACTIVE for max(len,1) clocks after start.
module pio_pulse_timer
  import pio_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             end_c
);

  pulse_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A zero length still produces a one-clock pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    end_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
          cnt_d   = (len == '0) ? '0 : len - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          end_c   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == ACTIVE);

endmodule

// File: rtl/pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear and a hardware-timed bit-inversion pulse.
module pio_out_pulse
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned RESET_VALUE   = 1,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned PULSE_DEFAULT = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             ie_q, ie_d;

  logic             wr_c;
  logic             start_c;
  logic             busy;
  logic             end_c;
  logic [WIDTH-1:0] wdata_c;
  logic             unused_wdata_c;

  assign wr_c           = chipselect & ~write_n;
  assign wdata_c        = writedata[WIDTH-1:0];
  assign unused_wdata_c = ^writedata;
  assign start_c        = wr_c && (address == ADDR_PULSE) && !busy && (wdata_c != '0);

  pio_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start_c),
    .len     (len_q),
    .busy    (busy),
    .end_c   (end_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= WIDTH'(RESET_VALUE);
      mask_q <= '0;
      len_q  <= CNT_W'(PULSE_DEFAULT);
      done_q <= 1'b0;
      ie_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      len_q  <= len_d;
      done_q <= done_d;
      ie_q   <= ie_d;
    end
  end

  // Register writes; pulse end is applied last so it wins over a same-edge done clear.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    len_d  = len_q;
    done_d = done_q;
    ie_d   = ie_q;
    if (wr_c) begin
      case (address)
        ADDR_DATA:      data_d = wdata_c;
        ADDR_SET:       data_d = data_q | wdata_c;
        ADDR_CLR:       data_d = data_q & ~wdata_c;
        ADDR_PULSE_LEN: len_d  = writedata[CNT_W-1:0];
        ADDR_STATUS: begin
          if (writedata[STATUS_DONE]) done_d = 1'b0;
          ie_d = writedata[STATUS_IE];
        end
        default: ;
      endcase
    end
    if (start_c) mask_d = wdata_c;
    if (end_c) begin
      mask_d = '0;
      done_d = 1'b1;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata = 32'(data_q);
      ADDR_PULSE:     readdata = 32'(mask_q);
      ADDR_PULSE_LEN: readdata = 32'(len_q);
      ADDR_STATUS: begin
        readdata[STATUS_BUSY] = busy;
        readdata[STATUS_DONE] = done_q;
        readdata[STATUS_IE]   = ie_q;
      end
      default: readdata = '0;
    endcase
  end

  assign out_port = data_q ^ mask_q;
  assign irq      = done_q & ie_q;

endmodule

// File: tb/tb_pio_out_pulse.sv
// Scoreboard bench for pio_out_pulse: a per-cycle behavioural model queues expected out_port/irq.
module tb_pio_out_pulse;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned RV    = 1;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned PD    = 1000;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;
  logic             irq;

  always #5 clk = ~clk;

  pio_out_pulse #(
    .WIDTH         (WIDTH),
    .RESET_VALUE   (RV),
    .CNT_W         (CNT_W),
    .PULSE_DEFAULT (PD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             irq;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int inv_cnt  = 0;

  // Reference model: m_rem is the number of inverted clocks still to come.
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] m_mask;
  int               m_rem;
  int               m_len;
  logic             m_done;
  logic             m_ie;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {29'd0, m_ie, m_done, (m_rem != 0)};
  endfunction

  task automatic step(input logic rst, input logic wr, input logic [2:0] a, input logic [31:0] d);
    exp_t e;
    exp_t got;
    logic ended;
    reset_n    = rst;
    chipselect = wr;
    write_n    = ~wr;
    address    = a;
    writedata  = d;
    ended      = 1'b0;
    if (!rst) begin
      m_data = WIDTH'(RV);
      m_mask = '0;
      m_rem  = 0;
      m_len  = PD;
      m_done = 1'b0;
      m_ie   = 1'b0;
    end else begin
      if (m_rem != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_mask = '0;
          ended  = 1'b1;
        end
      end else if (wr && a == 3'd3 && d[WIDTH-1:0] != '0) begin
        m_mask = d[WIDTH-1:0];
        m_rem  = (m_len == 0) ? 1 : m_len;
      end
      if (wr) begin
        case (a)
          3'd0: m_data = d[WIDTH-1:0];
          3'd1: m_data = m_data | d[WIDTH-1:0];
          3'd2: m_data = m_data & ~d[WIDTH-1:0];
          3'd4: m_len  = int'(d[CNT_W-1:0]);
          3'd5: begin
            if (d[1]) m_done = 1'b0;
            m_ie = d[2];
          end
          default: ;
        endcase
      end
      if (ended) m_done = 1'b1;
    end
    e.out = m_data ^ m_mask;
    e.irq = m_done & m_ie;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("out_port", 32'(out_port), 32'(got.out));
    check("irq", 32'(irq), 32'(got.irq));
    if ((out_port ^ m_data) != '0) inv_cnt++;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;

    // Reset state
    step(1'b0, 1'b0, 3'd0, 32'd0);
    step(1'b0, 1'b0, 3'd0, 32'd0);
    idle(1);
    check("rst_out", 32'(out_port), 32'h1);
    check("rst_irq", 32'(irq), 32'h0);
    rd(3'd0, 32'h1, "rst_data_rd");
    rd(3'd5, 32'h0, "rst_status_rd");
    rd(3'd4, 32'(PD), "rst_len_rd");

    // Plain and atomic writes; upper writedata bits ignored
    wr(3'd0, 32'hFFFF_FFFA);
    check("data_wr", 32'(out_port), 32'hA);
    wr(3'd1, 32'h4);
    check("set_wr", 32'(out_port), 32'hE);
    wr(3'd2, 32'h2);
    check("clr_wr", 32'(out_port), 32'hC);
    rd(3'd1, 32'h0, "set_rd");
    rd(3'd2, 32'h0, "clr_rd");
    rd(3'd6, 32'h0, "unmapped_rd");
    wr(3'd6, 32'hF);
    wr(3'd7, 32'h3);
    rd(3'd0, 32'hC, "unmapped_wr_ignored");

    // 5-clock pulse with interrupt
    wr(3'd4, 32'd5);
    wr(3'd5, 32'h4);
    wr(3'd0, 32'h1);
    inv_cnt = 0;
    wr(3'd3, 32'h1);
    check("pulse_out", 32'(out_port), 32'h0);
    rd(3'd5, 32'h5, "pulse_busy_rd");
    rd(3'd3, 32'h1, "pulse_mask_rd");
    idle(7);
    check("pulse_len5", 32'(inv_cnt), 32'd5);
    rd(3'd5, 32'h6, "pulse_done_rd");
    check("pulse_irq", 32'(irq), 32'h1);
    wr(3'd5, 32'h2);
    check("w1c_irq", 32'(irq), 32'h0);
    rd(3'd5, 32'h0, "w1c_status_rd");

    // Zero-mask pulse is a no-op
    wr(3'd5, 32'h4);
    wr(3'd3, 32'h0);
    rd(3'd5, 32'h4, "zero_mask_rd");

    // PULSE_LEN=0 behaves as 1
    wr(3'd4, 32'd0);
    inv_cnt = 0;
    wr(3'd3, 32'h8);
    rd(3'd4, 32'h0, "len0_rd");
    idle(3);
    check("pulse_len0", 32'(inv_cnt), 32'd1);
    rd(3'd5, 32'h6, "len0_done_rd");
    wr(3'd5, 32'h2);

    // Mid-pulse PULSE / PULSE_LEN / SET writes
    wr(3'd2, 32'h1);
    wr(3'd4, 32'd10);
    inv_cnt = 0;
    wr(3'd3, 32'h2);
    idle(2);
    wr(3'd3, 32'h4);
    wr(3'd4, 32'd3);
    wr(3'd1, 32'h1);
    check("mid_set", 32'(out_port), 32'h3);
    idle(10);
    check("mid_len10", 32'(inv_cnt), 32'd10);
    inv_cnt = 0;
    wr(3'd3, 32'h2);
    idle(5);
    check("next_len3", 32'(inv_cnt), 32'd3);

    // Reset mid-pulse
    wr(3'd4, 32'd10);
    wr(3'd0, 32'h6);
    wr(3'd3, 32'h1);
    idle(3);
    step(1'b0, 1'b0, 3'd0, 32'd0);
    check("rst_mid_out", 32'(out_port), 32'h1);
    rd(3'd5, 32'h0, "rst_mid_status");
    rd(3'd4, 32'(PD), "rst_mid_len");
    idle(2);

    // Glitch on reset_n between edges has no effect
    wr(3'd0, 32'h6);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    idle(2);
    check("glitch_out", 32'(out_port), 32'h6);
    rd(3'd4, 32'(PD), "glitch_len");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
